op_scheduler: RTL and testbench

//  Sequences the polynomial arithmetic unit (NTT/INTT/MULT/ADD/SUB engine) for the top-level controller.

---
 rtl/op_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_op_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_scheduler.sv
// ---------------------------------------------------------------------------
// op_scheduler
//   Sequences the polynomial arithmetic engine (NTT/INTT/MULT/ADD/SUB).
//   Commands {mode, encode, count} are queued in a small FIFO. Each command
//   issues one op_start pulse per polynomial. The engine mode and encode stay
//   stable while the engine works. After each op_done the scheduler advances
//   poly_idx. When the command ends it pulses rsp_valid with a status.
//   Illegal modes are rejected without starting the engine. A watchdog aborts
//   any polynomial whose op_done does not arrive in time.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready registered !full)
//   cmd_mode/encode/count       command fields (count 0 means 16)
//   op_start                    one-cycle start pulse to the engine
//   op_mode/op_encode           engine controls, held until the next load
//   op_done                     one-cycle done pulse from the engine
//   poly_idx                    polynomial in flight (bank select)
//   busy                        scheduler active or commands queued
//   rsp_valid/rsp_status        completion pulse: 0 OK, 1 TIMEOUT, 2 ILLEGAL
//   err_spurious                sticky flag: op_done seen outside BUSY
// ---------------------------------------------------------------------------
module op_scheduler #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_mode,
   input  logic [1:0] cmd_encode,
   input  logic [3:0] cmd_count,
   output logic       op_start,
   output logic [2:0] op_mode,
   output logic [1:0] op_encode,
   input  logic       op_done,
   output logic [3:0] poly_idx,
   output logic       busy,
   output logic       rsp_valid,
   output logic [1:0] rsp_status,
   output logic       err_spurious
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
   // BUSY is left on the edge at which the timer would reach TIMEOUT-1.
   // This places rsp_valid exactly TIMEOUT cycles after op_start.
   localparam logic [TW-1:0] EXPIRE_AT = TW'(TIMEOUT - 2);
   localparam logic [2:0]    MODE_MAX  = 3'd4;
   localparam logic [1:0]    ST_OK      = 2'd0;
   localparam logic [1:0]    ST_TIMEOUT = 2'd1;
   localparam logic [1:0]    ST_ILLEGAL = 2'd2;

   typedef enum logic [2:0] {IDLE, LOAD, START, BUSY, RESP} state_t;

   state_t        state_reg, state_next;
   logic [8:0]    fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg, count_next;
   logic          cmd_ready_reg;
   logic [8:0]    cmd_reg;
   logic [2:0]    cmd_mode_q;
   logic [1:0]    cmd_encode_q;
   logic [3:0]    cmd_count_q;
   logic [3:0]    poly_idx_reg, last_reg;
   logic [TW-1:0] timer_reg;
   logic [2:0]    op_mode_reg;
   logic [1:0]    op_encode_reg, status_reg;
   logic          err_reg;
   logic          push, pop, illegal, expire, at_last;

   assign push    = cmd_valid & cmd_ready_reg;
   assign pop     = (state_reg == IDLE) && (count_reg != '0);
   assign cmd_mode_q   = cmd_reg[8:6];
   assign cmd_encode_q = cmd_reg[5:4];
   assign cmd_count_q  = cmd_reg[3:0];
   assign illegal = (cmd_mode_q > MODE_MAX);
   assign expire  = (timer_reg == EXPIRE_AT);
   assign at_last = (poly_idx_reg == last_reg);

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Command storage and head read.
   // This block has no reset so that the array maps onto plain memory.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= {cmd_mode, cmd_encode, cmd_count};
      if (pop)  cmd_reg <= fifo_mem[rd_ptr_reg];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         cmd_ready_reg <= 1'b1;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
         // This flag is registered, so it stays low for the whole full cycle.
         // A pop in that same cycle does not raise it.
         cmd_ready_reg <= (count_next != FULL_CNT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (count_reg != '0) state_next = LOAD;
         LOAD:    state_next = illegal ? RESP : START;
         START:   state_next = BUSY;
         BUSY: begin
            // If op_done and the timer expiry fall in the same cycle, op_done wins.
            if (op_done)     state_next = at_last ? RESP : START;
            else if (expire) state_next = RESP;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         poly_idx_reg  <= '0;
         last_reg      <= '0;
         timer_reg     <= '0;
         op_mode_reg   <= '0;
         op_encode_reg <= '0;
         status_reg    <= ST_OK;
         err_reg       <= 1'b0;
      end else begin
         case (state_reg)
            LOAD: begin
               if (illegal) begin
                  status_reg <= ST_ILLEGAL;
               end else begin
                  op_mode_reg   <= cmd_mode_q;
                  op_encode_reg <= cmd_encode_q;
                  poly_idx_reg  <= '0;
                  last_reg      <= cmd_count_q - 4'd1;   // count 0 wraps to 15
               end
            end
            START: timer_reg <= '0;
            BUSY: begin
               if (timer_reg != '1) timer_reg <= timer_reg + 1'b1;
               if (op_done) begin
                  if (at_last) status_reg   <= ST_OK;
                  else         poly_idx_reg <= poly_idx_reg + 4'd1;
               end else if (expire) begin
                  status_reg <= ST_TIMEOUT;
               end
            end
            default: ;
         endcase
         if (op_done && (state_reg != BUSY)) err_reg <= 1'b1;
      end
   end

   assign cmd_ready    = cmd_ready_reg;
   assign op_start     = (state_reg == START);
   assign op_mode      = op_mode_reg;
   assign op_encode    = op_encode_reg;
   assign poly_idx     = poly_idx_reg;
   assign busy         = (state_reg != IDLE) || (count_reg != '0);
   assign rsp_valid    = (state_reg == RESP);
   assign rsp_status   = rsp_valid ? status_reg : 2'd0;
   assign err_spurious = err_reg;

endmodule

// File: tb/tb_op_scheduler.sv
// ---------------------------------------------------------------------------
// tb_op_scheduler
//   Directed and randomized checks of op_scheduler against a cycle-level
//   reference model.
//   Commands are pushed and their push edges are recorded. The model
//   predicts, for each command:
//     - the cycle, mode, encode and index of every op_start, and
//     - the cycle, status and held mode of the response.
//   A configurable engine model answers each op_start.
// ---------------------------------------------------------------------------
module tb_op_scheduler;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   logic       clk = 1'b0;
   logic       rst_n, cmd_valid, cmd_ready, op_start, op_done = 1'b0;
   logic [2:0] cmd_mode, op_mode;
   logic [1:0] cmd_encode, op_encode, rsp_status;
   logic [3:0] cmd_count, poly_idx;
   logic       busy, rsp_valid, err_spurious;

   op_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_encode(cmd_encode), .cmd_count(cmd_count),
      .op_start(op_start), .op_mode(op_mode), .op_encode(op_encode),
      .op_done(op_done), .poly_idx(poly_idx), .busy(busy),
      .rsp_valid(rsp_valid), .rsp_status(rsp_status), .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; int mode; int enc; int idx; } start_t;
   typedef struct { int cyc; int status; int mode; } rsp_t;
   typedef struct { int mode; int enc; int cnt; int pedge; } cmd_t;

   start_t obs_start[$], exp_start[$];
   rsp_t   obs_rsp[$],   exp_rsp[$];
   cmd_t   pend[$];
   int     n_checks = 0, n_fail = 0;
   int     model_last_mode = 0;
   bit     eng_hold = 1'b0, spur_req = 1'b0;
   int     eng_delay = 10, cd = 0;

   // Engine model: pulses op_done eng_delay cycles after the op_start cycle.
   always @(negedge clk) begin
      op_done = spur_req;
      if (!rst_n) cd = 0;
      else if (op_start && !eng_hold) cd = eng_delay;
      else if (cd > 0) begin
         cd = cd - 1;
         if (cd == 0) op_done = 1'b1;
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (op_start)  obs_start.push_back('{cyc, int'(op_mode), int'(op_encode), int'(poly_idx)});
         if (rsp_valid) obs_rsp.push_back('{cyc, int'(rsp_status), int'(op_mode)});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic push_cmd(input int mode, input int enc, input int cnt);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_mode = mode[2:0]; cmd_encode = enc[1:0]; cmd_count = cnt[3:0];
      while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
      if (!cmd_ready) begin
         chk("push_ready", cmd_ready, 1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      pend.push_back('{mode, enc, cnt, cyc});
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin @(negedge clk); n++; end
      chk("idle_reached", busy, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_start();
      int n = 0;
      @(negedge clk);
      while (!op_start && n < 200) begin @(negedge clk); n++; end
      chk("start_seen", op_start, 1);
   endtask

   // Reference model.
   // A command may not start before both of these:
   //   - 2 cycles after its push edge, and
   //   - 3 cycles after the previous response.
   // A legal command issues its polys every delay+1 cycles.
   // A timeout responds TIMEOUT cycles after its single start.
   task automatic run_model(input int delay, input bit hold);
      int last_rsp = -1000;
      foreach (pend[i]) begin
         cmd_t c = pend[i];
         int t = (last_rsp + 3 > c.pedge + 2) ? last_rsp + 3 : c.pedge + 2;
         if (c.mode > 4) begin
            exp_rsp.push_back('{t, 2, model_last_mode});
            last_rsp = t;
         end else begin
            int n = (c.cnt == 0) ? 16 : c.cnt;
            model_last_mode = c.mode;
            if (hold) begin
               exp_start.push_back('{t, c.mode, c.enc, 0});
               last_rsp = t + TIMEOUT;
               exp_rsp.push_back('{last_rsp, 1, c.mode});
            end else begin
               for (int k = 0; k < n; k++)
                  exp_start.push_back('{t + k * (delay + 1), c.mode, c.enc, k});
               last_rsp = t + n * (delay + 1);
               exp_rsp.push_back('{last_rsp, 0, c.mode});
            end
         end
      end
      pend.delete();
   endtask

   task automatic compare(input string tag);
      chk({tag, "_nstart"}, obs_start.size(), exp_start.size());
      for (int i = 0; i < obs_start.size() && i < exp_start.size(); i++) begin
         chk({tag, "_start_cyc"},  obs_start[i].cyc,  exp_start[i].cyc);
         chk({tag, "_start_mode"}, obs_start[i].mode, exp_start[i].mode);
         chk({tag, "_start_enc"},  obs_start[i].enc,  exp_start[i].enc);
         chk({tag, "_start_idx"},  obs_start[i].idx,  exp_start[i].idx);
      end
      chk({tag, "_nrsp"}, obs_rsp.size(), exp_rsp.size());
      for (int i = 0; i < obs_rsp.size() && i < exp_rsp.size(); i++) begin
         $display("%s rsp %0d: cycle %0d status %0d mode %0d", tag, i,
                  obs_rsp[i].cyc, obs_rsp[i].status, obs_rsp[i].mode);
         chk({tag, "_rsp_cyc"},    obs_rsp[i].cyc,    exp_rsp[i].cyc);
         chk({tag, "_rsp_status"}, obs_rsp[i].status, exp_rsp[i].status);
         chk({tag, "_rsp_mode"},   obs_rsp[i].mode,   exp_rsp[i].mode);
      end
      obs_start.delete(); exp_start.delete(); obs_rsp.delete(); exp_rsp.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_op_start"},  op_start, 0);
      chk({tag, "_op_mode"},   op_mode, 0);
      chk({tag, "_op_encode"}, op_encode, 0);
      chk({tag, "_poly_idx"},  poly_idx, 0);
      chk({tag, "_busy"},      busy, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_status"}, rsp_status, 0);
      chk({tag, "_err"},       err_spurious, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_encode = '0; cmd_count = '0;
      #3 rst_n = 1'b0;
      #2 chk_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Single ADD command of 3 polys; engine responds after 10 cycles
      eng_delay = 10;
      push_cmd(3, 0, 3);
      wait_idle(500);
      run_model(10, 0);
      compare("t1_add3");

      // One command occupies the scheduler, then 4 more fill the FIFO
      eng_delay = 30;
      push_cmd($urandom_range(0, 4), $urandom_range(0, 3), 2);
      wait_start();
      for (int i = 0; i < 4; i++) push_cmd($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(1, 2));
      chk("t2_full_ready", cmd_ready, 0);
      chk("t2_busy", busy, 1);
      wait_idle(2000);
      run_model(30, 0);
      compare("t2_fifo");

      // count 0 means 16 polys
      eng_delay = 2;
      push_cmd(0, $urandom_range(0, 3), 0);
      wait_idle(1000);
      chk("t3_idx_end", poly_idx, 15);
      run_model(2, 0);
      compare("t3_cnt16");

      // Illegal mode is rejected; the following command still runs
      eng_delay = 5;
      push_cmd(6, 1, 2);
      push_cmd(4, 2, 2);
      wait_idle(500);
      run_model(5, 0);
      compare("t4_illegal");

      // Engine never answers: watchdog timeout
      eng_hold = 1'b1;
      push_cmd($urandom_range(0, 4), $urandom_range(0, 3), 3);
      wait_idle(500);
      run_model(0, 1);
      compare("t5_timeout");
      chk("t5_err", err_spurious, 0);
      eng_hold = 1'b0;

      // op_done in the same cycle as the expiry: done wins
      eng_delay = TIMEOUT - 1;
      push_cmd(2, 3, 2);
      wait_idle(500);
      run_model(TIMEOUT - 1, 0);
      compare("t6_edge");

      // Randomized command mixes, including illegal modes and count 0
      for (int r = 0; r < 2; r++) begin
         int d = $urandom_range(1, 8);
         eng_delay = d;
         for (int i = 0; i < 6; i++)
            push_cmd($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));
         wait_idle(5000);
         run_model(d, 0);
         compare("t7_rand");
      end

      // Spurious op_done while idle
      chk("t8_err_before", err_spurious, 0);
      @(posedge clk); #1 spur_req = 1'b1;
      @(posedge clk); #1 spur_req = 1'b0;
      chk("t8_err_set", err_spurious, 1);

      // Reset during BUSY with commands queued
      eng_hold = 1'b1;
      push_cmd(1, 1, 4);
      wait_start();
      push_cmd(3, 2, 1);
      push_cmd(4, 0, 1);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1 chk_reset_outputs("t9_midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      eng_hold = 1'b0;
      pend.delete(); obs_start.delete(); obs_rsp.delete();
      model_last_mode = 0;
      repeat (20) @(negedge clk);
      chk("t9_no_rsp", obs_rsp.size(), 0);
      chk("t9_no_start", obs_start.size(), 0);
      chk("t9_busy", busy, 0);

      // Normal operation after reset
      eng_delay = 3;
      push_cmd(4, 1, 2);
      wait_idle(500);
      run_model(3, 0);
      compare("t10_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
